halfword_store_rmw: RTL and testbench

HALFWORD_STORE_RMW -- requirements
Module: halfword_store_rmw

---
 rtl/halfword_store_rmw_pkg.sv | 21 ++
 rtl/halfword_merge.sv | 15 +
 rtl/halfword_store_rmw.sv | 105 ++++++++++
 tb/tb_halfword_store_rmw.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/halfword_store_rmw_pkg.sv
// Shared types and constants for the halfword store read-modify-write engine.
// Holds the controller state encoding and the data-path widths.
package halfword_store_rmw_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DONE,
    ERR
  } fsmState;

  // Halfwords need 2-byte alignment, words need 4-byte alignment.
  function automatic logic isMisaligned(input logic [1:0] addrLsb, input logic half);
    return half ? addrLsb[0] : (addrLsb != 2'b00);
  endfunction

endpackage

// File: rtl/halfword_merge.sv
// Little-endian halfword insertion into a 32-bit word.
// sel = 0 replaces the low halfword, sel = 1 replaces the high halfword.
module halfword_merge
  import halfword_store_rmw_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [HALF_W-1:0] halfWord,
  input  logic              sel,
  output logic [WORD_W-1:0] merged
);

  assign merged = sel ? {halfWord, word[HALF_W-1:0]}
                      : {word[WORD_W-1:HALF_W], halfWord};

endmodule

// File: rtl/halfword_store_rmw.sv
// Store engine: word stores write straight through, halfword stores read the
// containing word, merge the new halfword in and write the result back.
module halfword_store_rmw
  import halfword_store_rmw_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] addr,
  input  logic              isHalf,
  input  logic [HALF_W-1:0] halfWord,
  input  logic [WORD_W-1:0] wordData,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_wready,
  output logic              done,
  output logic              busy,
  output logic              misaligned
);

  fsmState             state;
  fsmState             nextState;
  logic                accept;
  logic                reqMisaligned;
  logic                selHiQ;
  logic [HALF_W-1:0]   halfWordQ;
  logic [WORD_W-1:0]   mergedWord;

  assign accept        = req_valid && req_ready;
  assign reqMisaligned = isMisaligned(addr[1:0], isHalf);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: nextState gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (reqMisaligned) nextState = ERR;
          else if (isHalf)   nextState = RD;
          else               nextState = WR;
        end
      end
      RD:      if (mem_rvalid) nextState = WR;
      WR:      if (mem_wready) nextState = DONE;
      DONE:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture: lane select and halfword feed the merge; the word address
  // and word data live directly in the memory-side registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selHiQ    <= 1'b0;
      halfWordQ <= '0;
    end else if (accept) begin
      selHiQ    <= addr[1];
      halfWordQ <= halfWord;
    end
  end

  halfword_merge uMerge (
    .word     (mem_rdata),
    .halfWord (halfWordQ),
    .sel      (selHiQ),
    .merged   (mergedWord)
  );

  // Memory address/data only move when an access is being launched or the
  // read data arrives, so they hold their last values in all other states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept && !reqMisaligned) begin
      mem_addr <= {addr[WORD_W-1:2], 2'b00};
      if (!isHalf) mem_wdata <= wordData;
    end else if (state == RD && mem_rvalid) begin
      mem_wdata <= mergedWord;
    end
  end

  // Strobes decode straight from the state so reset removes them immediately.
  assign mem_rd     = (state == RD);
  assign mem_wr     = (state == WR);
  assign done       = (state == DONE);
  assign misaligned = (state == ERR);
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_halfword_store_rmw.sv
// Self-checking bench: a sparse memory model with programmable response delays,
// a per-transaction reference model, and a per-cycle compare process.
module tb_halfword_store_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] addr;
  logic        isHalf;
  logic [15:0] halfWord;
  logic [31:0] wordData;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_rd, mem_rvalid, mem_wr, mem_wready;
  logic        done, busy, misaligned;

  always #5 clk = ~clk;

  halfword_store_rmw dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .isHalf(isHalf), .halfWord(halfWord), .wordData(wordData),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .done(done), .busy(busy), .misaligned(misaligned)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Memory side: a sparse word store answering reads/writes after programmable delays.
  logic [31:0] memModel [logic [31:0]];
  int  rdDelay  = 1;
  int  wrDelay  = 1;
  bit  spurious = 0;
  int  rdCnt    = 0;
  int  wrCnt    = 0;

  always @(posedge clk) begin
    #1;
    if (mem_rd) begin
      rdCnt++;
      mem_rvalid = (rdCnt == rdDelay);
      mem_rdata  = memModel.exists(mem_addr) ? memModel[mem_addr] : 32'h0;
    end else begin
      rdCnt      = 0;
      mem_rvalid = spurious && mem_wr;
      mem_rdata  = 32'hDEAD_DEAD;
    end
    if (mem_wr) begin
      wrCnt++;
      mem_wready = (wrCnt == wrDelay);
      if (mem_wready) memModel[mem_addr] = mem_wdata;
    end else begin
      wrCnt      = 0;
      mem_wready = spurious && mem_rd;
    end
  end

  // Expectations for the transaction in flight, set by the driver.
  logic [31:0] expAddr = 32'h0;
  logic [31:0] expData = 32'h0;
  bit          noMem   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'h0);
      check("busy_vs_ready", 32'(busy), 32'(!req_ready));
      if (noMem) check("no_mem_on_err", 32'(mem_rd | mem_wr), 32'h0);
      if (mem_rd) check("rd_addr", mem_addr, expAddr);
      if (mem_wr) begin
        check("wr_addr", mem_addr, expAddr);
        check("wr_data", mem_wdata, expData);
      end
    end
  end

  task automatic doStore(input logic [31:0] a, input bit h, input logic [15:0] hw,
                         input logic [31:0] wd, input int rdD, input int wrD,
                         input bit spur, input string tag);
    logic [31:0] wa, old;
    bit          mis;
    int          lat, nRd, nWr, nDone, nMis, doneAt, misAt, window;
    wa  = a & 32'hFFFF_FFFC;
    mis = h ? a[0] : (a[1:0] != 2'b00);
    old = memModel.exists(wa) ? memModel[wa] : 32'h0;
    expAddr = wa;
    if (!h)        expData = wd;
    else if (a[1]) expData = (old & 32'h0000_FFFF) | (32'(hw) << 16);
    else           expData = (old & 32'hFFFF_0000) | 32'(hw);
    lat      = h ? rdD + wrD + 1 : wrD + 1;
    rdDelay  = rdD;
    wrDelay  = wrD;
    spurious = spur;
    noMem    = mis;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; addr = a; isHalf = h; halfWord = hw; wordData = wd;
    @(negedge clk);
    req_valid = 1'b0; addr = ~a; isHalf = ~h; halfWord = ~hw; wordData = ~wd;
    nRd = 0; nWr = 0; nDone = 0; nMis = 0; doneAt = 0; misAt = 0;
    window = mis ? 4 : lat + 3;
    for (int c = 1; c <= window; c++) begin
      if (c > 1) @(negedge clk);
      nRd   += int'(mem_rd);
      nWr   += int'(mem_wr);
      nDone += int'(done);
      nMis  += int'(misaligned);
      if (done && doneAt == 0) doneAt = c;
      if (misaligned && misAt == 0) misAt = c;
    end
    if (mis) begin
      check({tag, "_mis_pulses"}, 32'(nMis), 32'd1);
      check({tag, "_mis_at"}, 32'(misAt), 32'd1);
      check({tag, "_no_done"}, 32'(nDone), 32'd0);
      check({tag, "_no_access"}, 32'(nRd + nWr), 32'd0);
    end else begin
      check({tag, "_done_pulses"}, 32'(nDone), 32'd1);
      check({tag, "_latency"}, 32'(doneAt), 32'(lat));
      check({tag, "_rd_cycles"}, 32'(nRd), 32'(h ? rdD : 0));
      check({tag, "_wr_cycles"}, 32'(nWr), 32'(wrD));
      check({tag, "_no_mis"}, 32'(nMis), 32'd0);
    end
    noMem    = 0;
    spurious = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nDone;
    reset = 1'b1; req_valid = 1'b0; addr = '0; isHalf = 1'b0; halfWord = '0; wordData = '0;
    mem_rvalid = 1'b0; mem_wready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_misaligned", 32'(misaligned), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    memModel[32'h100] = 32'h1234_5678;
    doStore(32'h100, 1, 16'hBEEF, 32'h0, 1, 1, 0, "hw_lo");
    check("hw_lo_mem", memModel[32'h100], 32'h1234_BEEF);

    memModel[32'h100] = 32'h1234_5678;
    doStore(32'h102, 1, 16'hBEEF, 32'h0, 1, 1, 0, "hw_hi");
    check("hw_hi_mem", memModel[32'h100], 32'hBEEF_5678);

    doStore(32'h200, 0, 16'h0, 32'hCAFE_F00D, 0, 1, 0, "word");
    check("word_mem", memModel[32'h200], 32'hCAFE_F00D);

    doStore(32'h101, 1, 16'h5555, 32'h0, 1, 1, 0, "mis_half");
    doStore(32'h202, 0, 16'h0, 32'h1111_2222, 0, 1, 0, "mis_word");
    doStore(32'h203, 1, 16'h6666, 32'h0, 1, 1, 0, "mis_half3");
    doStore(32'h201, 0, 16'h0, 32'h3333_4444, 0, 1, 0, "mis_word1");
    check("mis_no_write", memModel.exists(32'h200) ? memModel[32'h200] : 32'h0, 32'hCAFE_F00D);

    memModel[32'h400] = 32'h0BAD_F00D;
    doStore(32'h400, 1, 16'h1234, 32'h0, 5, 3, 1, "slow_hw");
    check("slow_hw_mem", memModel[32'h400], 32'h0BAD_1234);

    doStore(32'h404, 0, 16'h0, 32'h8765_4321, 0, 3, 1, "slow_word");
    check("slow_word_mem", memModel[32'h404], 32'h8765_4321);

    // Abandon a halfword store while its read is outstanding.
    memModel[32'h300] = 32'hA5A5_A5A5;
    expAddr = 32'h300;
    rdDelay = 20;
    @(negedge clk);
    req_valid = 1'b1; addr = 32'h302; isHalf = 1'b1; halfWord = 16'h1111;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2;
    check("mid_rd_before_reset", 32'(mem_rd), 32'h1);
    reset = 1'b1;
    #1;
    check("async_rd_drop", 32'(mem_rd), 32'h0);
    check("async_busy_drop", 32'(busy), 32'h0);
    check("async_addr_clear", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nDone = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nDone += int'(done);
    end
    check("abandon_no_done", 32'(nDone), 32'h0);
    check("abandon_no_write", memModel[32'h300], 32'hA5A5_A5A5);

    doStore(32'h302, 1, 16'h7777, 32'h0, 1, 1, 0, "after_rst");
    check("after_rst_mem", memModel[32'h300], 32'h7777_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
